// File: rtl/router_pkg.sv
// Shared router encodings: flit types, output ports, VC states and XY routing.
package router_pkg;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_TAIL      = 2'b01,
    FT_HEAD      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    VC_IDLE   = 2'b00,
    VC_ROUTE  = 2'b01,
    VC_ACTIVE = 2'b10
  } vc_state_e;

  // Dimension-ordered routing: resolve X first, then Y, then deliver locally.
  function automatic port_e xy_route(input int unsigned dest_x, input int unsigned dest_y,
                                     input int unsigned local_x, input int unsigned local_y);
    if (dest_x > local_x)      return PORT_EAST;
    else if (dest_x < local_x) return PORT_WEST;
    else if (dest_y > local_y) return PORT_NORTH;
    else if (dest_y < local_y) return PORT_SOUTH;
    else                       return PORT_LOCAL;
  endfunction

  function automatic logic is_head(input flit_type_e t);
    return (t == FT_HEAD) || (t == FT_HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == FT_TAIL) || (t == FT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/vc_input_unit_if.sv
// Bundle of the upstream link and crossbar-arbiter handshake of one router input.
//
// Handshake: flit_valid is a push with no ready. The upstream sender may only
// push a flit into a VC for which it holds a credit; the input unit returns one
// credit (credit_valid, credit_vc) for every flit it removes from a VC buffer.
// Toward the switch allocator, sw_req[i] is a level request and sw_gnt must be
// one-hot among requesting VCs; a granted VC is dequeued on that clock edge.
interface vc_input_unit_if #(
  parameter int FLIT_W = 32,
  parameter int NUM_VC = 2,
  parameter int VC_W   = 1
);
  logic              flit_valid;
  logic [FLIT_W-1:0] flit;
  logic [VC_W-1:0]   flit_vc;
  logic              credit_valid;
  logic [VC_W-1:0]   credit_vc;
  logic [NUM_VC-1:0] sw_gnt;
  logic [NUM_VC-1:0] sw_req;

  modport master (
    output flit_valid, flit, flit_vc, sw_gnt,
    input  credit_valid, credit_vc, sw_req
  );

  modport slave (
    input  flit_valid, flit, flit_vc, sw_gnt,
    output credit_valid, credit_vc, sw_req
  );
endinterface

// File: rtl/sfifo.sv
// Synchronous FIFO with show-ahead read data; a pop frees a slot for a
// same-cycle push even when full.
module sfifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_rd;
  logic          do_wr;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/vc_input_unit.sv
// Router input unit: per-VC flit buffers, per-VC route/activation FSMs,
// switch request generation, registered crossbar output and credit return.
module vc_input_unit
  import router_pkg::*;
#(
  parameter int FLIT_W   = 32,
  parameter int NUM_VC   = 2,
  parameter int VC_DEPTH = 4,
  parameter int COORD_W  = 4,
  parameter int LOCAL_X  = 1,
  parameter int LOCAL_Y  = 1,
  localparam int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_flit_valid,
  input  logic [FLIT_W-1:0]   i_flit,
  input  logic [VC_W-1:0]     i_flit_vc,
  input  logic [NUM_VC-1:0]   i_sw_gnt,
  output logic [NUM_VC-1:0]   o_sw_req,
  output logic [3*NUM_VC-1:0] o_route,
  output logic                o_flit_valid,
  output logic [FLIT_W-1:0]   o_flit,
  output logic                o_credit_valid,
  output logic [VC_W-1:0]     o_credit_vc,
  output logic [2*NUM_VC-1:0] o_vc_state,
  output logic                o_err
);

  logic [FLIT_W-1:0] front [NUM_VC];
  flit_type_e        front_type [NUM_VC];
  port_e             route_calc [NUM_VC];
  port_e             route_q [NUM_VC];
  vc_state_e         state [NUM_VC];

  logic [NUM_VC-1:0] wr_en;
  logic [NUM_VC-1:0] fifo_full;
  logic [NUM_VC-1:0] fifo_empty;
  logic [NUM_VC-1:0] sw_req;
  logic [NUM_VC-1:0] discard_cand;
  logic [NUM_VC-1:0] discard_en;
  logic [NUM_VC-1:0] grant_pop;
  logic [NUM_VC-1:0] pop;
  logic              gnt_legal;
  logic              gnt_err;
  logic              drop_err;
  logic              bad_vc;
  logic              disc_found;
  logic [VC_W-1:0]   pop_idx;
  logic [FLIT_W-1:0] sel_flit;

  assign bad_vc = i_flit_valid && (int'(i_flit_vc) >= NUM_VC);

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign wr_en[i] = i_flit_valid && (i_flit_vc == VC_W'(i));

    sfifo #(.W(FLIT_W), .DEPTH(VC_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .wr_en   (wr_en[i]),
      .wr_data (i_flit),
      .rd_en   (pop[i]),
      .rd_data (front[i]),
      .full    (fifo_full[i]),
      .empty   (fifo_empty[i])
    );

    assign front_type[i]   = flit_type_e'(front[i][FLIT_W-1 -: 2]);
    assign route_calc[i]   = xy_route(32'(front[i][2*COORD_W-1:COORD_W]),
                                      32'(front[i][COORD_W-1:0]),
                                      LOCAL_X, LOCAL_Y);
    assign sw_req[i]       = (state[i] == VC_ACTIVE) && !fifo_empty[i];
    // A non-head flit at the front of an idle VC has lost its packet context.
    assign discard_cand[i] = (state[i] == VC_IDLE) && !fifo_empty[i] && !is_head(front_type[i]);

    assign o_route[3*i +: 3]    = route_q[i];
    assign o_vc_state[2*i +: 2] = state[i];
  end

  assign o_sw_req = sw_req;

  // Grant checking and pop selection. Discards only use a cycle the crossbar
  // leaves free and only one per cycle, so a single credit port suffices.
  always_comb begin
    gnt_legal  = $onehot0(i_sw_gnt) && ((i_sw_gnt & ~sw_req) == '0);
    gnt_err    = (i_sw_gnt != '0) && !gnt_legal;
    grant_pop  = gnt_legal ? (i_sw_gnt & sw_req) : '0;
    discard_en = '0;
    disc_found = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!disc_found && (grant_pop == '0) && discard_cand[i]) begin
        discard_en[i] = 1'b1;
        disc_found    = 1'b1;
      end
    end
    pop      = grant_pop | discard_en;
    drop_err = |(wr_en & fifo_full & ~pop);
  end

  // Index and front flit of the VC being popped this cycle (pop is one-hot or zero).
  always_comb begin
    pop_idx  = '0;
    sel_flit = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (pop[i]) begin
        pop_idx  = VC_W'(i);
        sel_flit = front[i];
      end
    end
  end

  // Per-VC packet FSM: wait for a head, latch its route for one cycle, then
  // forward until the tail leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VC; i++) begin
        state[i]   <= VC_IDLE;
        route_q[i] <= PORT_LOCAL;
      end
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        case (state[i])
          VC_IDLE: begin
            if (!fifo_empty[i] && is_head(front_type[i])) state[i] <= VC_ROUTE;
          end
          VC_ROUTE: begin
            route_q[i] <= route_calc[i];
            state[i]   <= VC_ACTIVE;
          end
          VC_ACTIVE: begin
            if (grant_pop[i] && is_tail(front_type[i])) state[i] <= VC_IDLE;
          end
          default: state[i] <= VC_IDLE;
        endcase
      end
    end
  end

  // Registered crossbar flit, credit return and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_flit_valid   <= 1'b0;
      o_flit         <= '0;
      o_credit_valid <= 1'b0;
      o_credit_vc    <= '0;
      o_err          <= 1'b0;
    end else begin
      o_flit_valid   <= |grant_pop;
      o_flit         <= (|grant_pop) ? sel_flit : '0;
      o_credit_valid <= |pop;
      o_credit_vc    <= pop_idx;
      o_err          <= o_err | bad_vc | drop_err | gnt_err | (|discard_en);
    end
  end

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit with hand-computed expectations.
module tb_vc_input_unit;
  import router_pkg::*;

  localparam int FLIT_W = 32;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 1;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [3*NUM_VC-1:0] route;
  logic                flit_valid_o;
  logic [FLIT_W-1:0]   flit_o;
  logic [2*NUM_VC-1:0] vc_state;
  logic                err;

  int errors = 0;
  int checks = 0;
  int cnt;

  logic [FLIT_W-1:0] exp_f [4];

  vc_input_unit_if #(.FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .VC_W(VC_W)) up ();

  vc_input_unit #(
    .FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .VC_DEPTH(4), .COORD_W(4), .LOCAL_X(1), .LOCAL_Y(1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_flit_valid   (up.flit_valid),
    .i_flit         (up.flit),
    .i_flit_vc      (up.flit_vc),
    .i_sw_gnt       (up.sw_gnt),
    .o_sw_req       (up.sw_req),
    .o_route        (route),
    .o_flit_valid   (flit_valid_o),
    .o_flit         (flit_o),
    .o_credit_valid (up.credit_valid),
    .o_credit_vc    (up.credit_vc),
    .o_vc_state     (vc_state),
    .o_err          (err)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [7:0] pay,
                                           input logic [3:0] x, input logic [3:0] y);
    return {t, 14'h0, pay, x, y};
  endfunction

  // Push one flit on the write edge, then release the link.
  task automatic send(input logic [VC_W-1:0] vc, input logic [FLIT_W-1:0] f);
    up.flit_valid = 1'b1;
    up.flit_vc    = vc;
    up.flit       = f;
    tick();
    up.flit_valid = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    up.flit_valid = 1'b0;
    up.flit       = '0;
    up.flit_vc    = '0;
    up.sw_gnt     = '0;
    tick();
    tick();

    // Reset state
    chk("rst_flit_valid", flit_valid_o, 0);
    chk("rst_flit", flit_o, 0);
    chk("rst_credit_valid", up.credit_valid, 0);
    chk("rst_credit_vc", up.credit_vc, 0);
    chk("rst_route", route, 0);
    chk("rst_err", err, 0);
    chk("rst_vc_state", vc_state, 0);
    chk("rst_sw_req", up.sw_req, 0);
    reset_n = 1'b1;
    tick();

    // Head dest(3,1) on VC0: EAST, request two edges after the write
    send(0, mk(2'b10, 8'hA1, 4'd3, 4'd1));
    chk("a_state_e0", vc_state, 4'b0000);
    chk("a_req_e0", up.sw_req, 2'b00);
    tick();
    chk("a_state_e1", vc_state, 4'b0001);
    chk("a_req_e1", up.sw_req, 2'b00);
    tick();
    chk("a_state_e2", vc_state, 4'b0010);
    chk("a_req_e2", up.sw_req, 2'b01);
    chk("a_route", route[2:0], 3'd2);
    up.sw_gnt = 2'b01;
    tick();
    up.sw_gnt = 2'b00;
    chk("a_flit_valid", flit_valid_o, 1);
    chk("a_flit", flit_o, mk(2'b10, 8'hA1, 4'd3, 4'd1));
    chk("a_credit_valid", up.credit_valid, 1);
    chk("a_credit_vc", up.credit_vc, 0);
    chk("a_req_empty", up.sw_req, 2'b00);
    tick();
    chk("a_flit_valid_1cyc", flit_valid_o, 0);
    chk("a_credit_1cyc", up.credit_valid, 0);
    chk("a_err", err, 0);
    send(0, mk(2'b01, 8'hA2, 4'd0, 4'd0));
    chk("a_req_tail", up.sw_req, 2'b01);
    up.sw_gnt = 2'b01;
    tick();
    up.sw_gnt = 2'b00;
    chk("a_tail_flit", flit_o, mk(2'b01, 8'hA2, 4'd0, 4'd0));
    chk("a_tail_idle", vc_state, 4'b0000);

    // Interleaved heads: VC0 dest(1,0) SOUTH, VC1 dest(1,1) LOCAL
    send(0, mk(2'b10, 8'hB1, 4'd1, 4'd0));
    send(1, mk(2'b10, 8'hB2, 4'd1, 4'd1));
    chk("b_state_f1", vc_state, 4'b0001);
    tick();
    chk("b_state_f2", vc_state, 4'b0110);
    chk("b_route_vc0", route[2:0], 3'd3);
    tick();
    chk("b_state_f3", vc_state, 4'b1010);
    chk("b_route_both", route, 6'b000_011);
    chk("b_req", up.sw_req, 2'b11);
    up.sw_gnt = 2'b10;
    tick();
    chk("b_flit_vc1", flit_o, mk(2'b10, 8'hB2, 4'd1, 4'd1));
    chk("b_credit_vc1", up.credit_vc, 1);
    up.sw_gnt = 2'b01;
    tick();
    up.sw_gnt = 2'b00;
    chk("b_flit_vc0", flit_o, mk(2'b10, 8'hB1, 4'd1, 4'd0));
    chk("b_credit_vc0", up.credit_vc, 0);
    chk("b_err", err, 0);

    // Five flits into VC1 (depth 4) with no grant: fifth dropped
    exp_f[0] = mk(2'b00, 8'hC1, 4'd0, 4'd0);
    exp_f[1] = mk(2'b00, 8'hC2, 4'd0, 4'd0);
    exp_f[2] = mk(2'b00, 8'hC3, 4'd0, 4'd0);
    exp_f[3] = mk(2'b01, 8'hC4, 4'd0, 4'd0);
    for (int k = 0; k < 4; k++) send(1, exp_f[k]);
    chk("c_err_before", err, 0);
    send(1, mk(2'b00, 8'hC5, 4'd0, 4'd0));
    chk("c_err_drop", err, 1);
    chk("c_req", up.sw_req, 2'b10);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      up.sw_gnt = (k < 4) ? 2'b10 : 2'b00;
      tick();
      if (up.credit_valid === 1'b1 && up.credit_vc === 1'b1) cnt++;
      if (k < 4) chk($sformatf("c_drain%0d", k), flit_o, exp_f[k]);
    end
    up.sw_gnt = 2'b00;
    chk("c_credits", cnt, 4);
    chk("c_vc1_idle", vc_state[3:2], 2'b00);
    chk("c_req_empty", up.sw_req, 2'b00);

    // Reset mid-packet: everything cleared, buffered flits never credited
    send(0, mk(2'b00, 8'hD1, 4'd0, 4'd0));
    send(0, mk(2'b00, 8'hD2, 4'd0, 4'd0));
    chk("d_req_pre", up.sw_req, 2'b01);
    reset_n = 1'b0;
    #1;
    chk("d_flit_valid", flit_valid_o, 0);
    chk("d_flit", flit_o, 0);
    chk("d_credit_valid", up.credit_valid, 0);
    chk("d_route", route, 0);
    chk("d_err", err, 0);
    chk("d_vc_state", vc_state, 0);
    chk("d_req", up.sw_req, 0);
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (up.credit_valid !== 1'b0 || flit_valid_o !== 1'b0) cnt++;
    end
    chk("d_no_credits", cnt, 0);
    chk("d_state_after", vc_state, 0);

    // Full VC0: write and grant together, nothing lost
    exp_f[0] = mk(2'b00, 8'hE1, 4'd0, 4'd0);
    exp_f[1] = mk(2'b00, 8'hE2, 4'd0, 4'd0);
    exp_f[2] = mk(2'b00, 8'hE3, 4'd0, 4'd0);
    exp_f[3] = mk(2'b01, 8'hE4, 4'd0, 4'd0);
    send(0, mk(2'b10, 8'hE0, 4'd1, 4'd1));
    for (int k = 0; k < 3; k++) send(0, exp_f[k]);
    chk("e_req_full", up.sw_req, 2'b01);
    chk("e_route_local", route[2:0], 3'd0);
    up.flit_valid = 1'b1;
    up.flit_vc    = 1'b0;
    up.flit       = exp_f[3];
    up.sw_gnt     = 2'b01;
    tick();
    up.flit_valid = 1'b0;
    chk("e_flit_head", flit_o, mk(2'b10, 8'hE0, 4'd1, 4'd1));
    chk("e_credit", up.credit_valid, 1);
    chk("e_err", err, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("e_drain%0d", k), flit_o, exp_f[k]);
    end
    up.sw_gnt = 2'b00;
    chk("e_req_empty", up.sw_req, 2'b00);
    chk("e_idle", vc_state, 4'b0000);
    chk("e_err_after", err, 0);

    // Multi-hot grant: no pop, error
    send(0, mk(2'b10, 8'hF0, 4'd2, 4'd1));
    send(1, mk(2'b10, 8'hF1, 4'd0, 4'd1));
    tick();
    tick();
    chk("f_req", up.sw_req, 2'b11);
    chk("f_route", route, {3'd4, 3'd2});
    up.sw_gnt = 2'b11;
    tick();
    up.sw_gnt = 2'b00;
    chk("f_flit_valid", flit_valid_o, 0);
    chk("f_credit_valid", up.credit_valid, 0);
    chk("f_err", err, 1);
    chk("f_req_kept", up.sw_req, 2'b11);

    // Body at the front of an idle VC: discarded, credited, error
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send(1, mk(2'b00, 8'h77, 4'd0, 4'd0));
    chk("g_credit_pre", up.credit_valid, 0);
    tick();
    chk("g_credit", up.credit_valid, 1);
    chk("g_credit_vc", up.credit_vc, 1);
    chk("g_flit_valid", flit_valid_o, 0);
    chk("g_err", err, 1);
    chk("g_state", vc_state, 4'b0000);
    tick();
    chk("g_credit_once", up.credit_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_input_unit.md
VC_INPUT_UNIT -- requirements
Module: vc_input_unit

Interface
REQ-001 SHALL have parameter FLIT_W, default 32, flit width in bits.
REQ-002 SHALL have parameter NUM_VC, default 2, number of virtual channels (>=1).
REQ-003 SHALL have parameter VC_DEPTH, default 4, flits per VC buffer (power of 2, >=2).
REQ-004 SHALL have parameter COORD_W, default 4, width of each X/Y coordinate.
REQ-005 SHALL have parameters LOCAL_X and LOCAL_Y, both default 1, this router's coordinates.
REQ-006 SHALL have ports, in this order:
  clk  in  1  single clock, rising edge.
  reset_n  in  1  asynchronous active-low reset.
  i_flit_valid  in  1  upstream flit present this cycle.
  i_flit  in  FLIT_W  flit; [FLIT_W-1:FLIT_W-2] type, [2*COORD_W-1:COORD_W] dest X, [COORD_W-1:0] dest Y.
  i_flit_vc  in  VC_W  target VC; VC_W = max(1, clog2(NUM_VC)).
  i_sw_gnt  in  NUM_VC  switch grant, one-hot or zero.
  o_sw_req  out  NUM_VC  per-VC switch request.
  o_route  out  3*NUM_VC  per-VC output port, VC i in bits [3i+2:3i].
  o_flit_valid  out  1  registered flit to crossbar.
  o_flit  out  FLIT_W  registered flit data.
  o_credit_valid  out  1  one buffer slot freed.
  o_credit_vc  out  VC_W  VC whose slot was freed.
  o_vc_state  out  2*NUM_VC  per-VC FSM state.
  o_err  out  1  sticky error flag.

Function
REQ-007 Flit type encoding SHALL be BODY=00, TAIL=01, HEAD=10, HEAD_TAIL=11.
REQ-008 Each VC SHALL own a FIFO of VC_DEPTH flits, written when i_flit_valid and i_flit_vc matches its index.
REQ-009 A write to a full VC SHALL be dropped and SHALL set o_err; FIFO contents and pointers stay unchanged.
REQ-010 A write with i_flit_vc >= NUM_VC SHALL be dropped and SHALL set o_err.
REQ-011 A simultaneous write and pop on the same VC SHALL both take effect, including when that VC is full.
REQ-012 Each VC FSM SHALL have states IDLE=00, ROUTE=01, ACTIVE=10.
REQ-013 IDLE->ROUTE SHALL occur when the FIFO front is HEAD or HEAD_TAIL; a BODY/TAIL at the front in IDLE SHALL be popped, discarded and SHALL set o_err.
REQ-014 ROUTE SHALL last exactly one cycle, latch the XY route of the front flit into o_route, then go to ACTIVE.
REQ-015 XY route: destX>LOCAL_X EAST=2; destX<LOCAL_X WEST=4; else destY>LOCAL_Y NORTH=1; destY<LOCAL_Y SOUTH=3; else LOCAL=0.
REQ-016 o_sw_req[i] SHALL be 1 iff VC i is ACTIVE and its FIFO is non-empty (combinational).
REQ-017 i_sw_gnt[i] with o_sw_req[i]=1 SHALL pop VC i; o_flit/o_flit_valid SHALL present that flit the next cycle, for one cycle.
REQ-018 o_credit_valid and o_credit_vc SHALL be registered and asserted in the same cycle as o_flit_valid, for every pop, including REQ-013 discards.
REQ-019 A grant to a non-requesting VC, or a multi-hot i_sw_gnt, SHALL pop nothing and SHALL set o_err.
REQ-020 Popping a TAIL or HEAD_TAIL flit SHALL return the VC to IDLE the next cycle; o_route SHALL hold its last value.
REQ-021 Throughput SHALL be one flit per cycle per input; head-to-first-request latency SHALL be 2 cycles from the write edge.

Reset
REQ-022 reset_n low SHALL asynchronously clear all FIFOs, set all VCs to IDLE, and drive o_flit=0, o_flit_valid=0, o_credit_valid=0, o_credit_vc=0, o_route=0 and o_err=0.
REQ-023 Reset asserted mid-packet SHALL discard all buffered flits; no credits SHALL be issued for them.

Structure
REQ-024 Flit type, port and VC state encodings SHALL be typedefs in router_pkg.
REQ-025 Per-VC storage SHALL reuse sfifo, one instance per VC, through a generate loop; the route function SHALL live in router_pkg.

Verification
REQ-026 Write HEAD dest(3,1) to VC0, then hold i_sw_gnt=01 -> o_sw_req[0] high 2 cycles after the write, o_route[2:0]=2 (EAST), flit and credit(vc0) out 1 cycle after grant.
REQ-027 Write 5 flits to VC1 with no grant at DEPTH=4 -> 4 stored, o_err=1, exactly 4 credits once drained.
REQ-028 Interleave HEAD dest(1,0) on VC0 and HEAD dest(1,1) on VC1 -> o_route VC0=3 (SOUTH), VC1=0 (LOCAL), independent FSMs.
REQ-029 Full VC0: write and grant in the same cycle -> no drop, o_err stays 0, occupancy stays 4.
REQ-030 i_sw_gnt=11 -> no pop, no o_flit_valid, o_err=1.
REQ-031 Assert reset_n=0 for 1 cycle mid-packet -> all outputs 0, o_vc_state all IDLE, no credits afterward.
